// File: rtl/exc_pkg.sv
// Shared types and exception codes for the MEM-stage exception/commit controller.
package exc_pkg;

    localparam logic [5:0] EXC_INT  = 6'd0;
    localparam logic [5:0] EXC_ADEL = 6'd4;
    localparam logic [5:0] EXC_ADES = 6'd5;
    localparam logic [5:0] EXC_SYS  = 6'd8;
    localparam logic [5:0] EXC_BP   = 6'd9;
    localparam logic [5:0] EXC_RI   = 6'd10;
    localparam logic [5:0] EXC_OV   = 6'd12;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } exc_state_t;

    typedef struct packed {
        logic if_adel;
        logic ri;
        logic ov;
        logic syscall;
        logic brk;
        logic adel;
        logic ades;
    } exc_flags_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder picking the single winning exception for the MEM instruction.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       int_pending,
    input  exc_flags_t flags,
    output logic       hit,
    output logic [5:0] code,
    output logic       is_bad_addr,
    output logic       bad_sel
);

    // bad_sel=1 takes BadVAddr from the instruction PC, 0 from the data address.
    always_comb begin
        // NOTE: every output gets a default first so no path through the chain infers a latch.
        hit         = 1'b1;
        code        = EXC_INT;
        is_bad_addr = 1'b0;
        bad_sel     = 1'b0;
        if (int_pending) begin
            code = EXC_INT;
        end else if (flags.if_adel) begin
            code        = EXC_ADEL;
            is_bad_addr = 1'b1;
            bad_sel     = 1'b1;
        end else if (flags.ri) begin
            code = EXC_RI;
        end else if (flags.ov) begin
            code = EXC_OV;
        end else if (flags.syscall) begin
            code = EXC_SYS;
        end else if (flags.brk) begin
            code = EXC_BP;
        end else if (flags.adel) begin
            code        = EXC_ADEL;
            is_bad_addr = 1'b1;
        end else if (flags.ades) begin
            code        = EXC_ADES;
            is_bad_addr = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception and commit controller: selects one event per instruction,
// drives CP0, then issues a registered redirect and a multi-cycle pipeline flush.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic        m_stall,
    input  logic [31:0] m_pc,
    input  logic        m_in_delay_slot,
    input  logic        m_if_adel,
    input  logic        m_ri,
    input  logic        m_ov,
    input  logic        m_syscall,
    input  logic        m_break,
    input  logic        m_adel,
    input  logic        m_ades,
    input  logic [31:0] m_data_addr,
    input  logic        m_eret,
    input  logic        m_cp0_write,
    input  logic        interrupt,
    input  logic [31:0] cp0_epc,
    output logic        exception,
    output logic [5:0]  m_excCode,
    output logic        isBadAddr,
    output logic [31:0] invalid_addr,
    output logic [31:0] excPC,
    output logic        inDelaySlot,
    output logic        ERET2pc,
    output logic        cp0_write,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    exc_state_t state, state_next;
    logic [3:0] counter, counter_next;
    logic       int_pending;

    exc_flags_t flags;
    logic       hit;
    logic [5:0] code;
    logic       is_bad_addr;
    logic       bad_sel;
    logic       accept;
    logic       win;
    logic       eret_commit;

    assign flags = '{if_adel: m_if_adel, ri: m_ri, ov: m_ov, syscall: m_syscall,
                     brk: m_break, adel: m_adel, ades: m_ades};

    exc_prio_enc u_prio (
        .int_pending (int_pending),
        .flags       (flags),
        .hit         (hit),
        .code        (code),
        .is_bad_addr (is_bad_addr),
        .bad_sel     (bad_sel)
    );

    assign accept      = (state == IDLE) && m_valid && !m_stall;
    assign win         = accept && hit;
    assign eret_commit = accept && !hit && m_eret;

    always_comb begin
        exception    = 1'b0;
        m_excCode    = 6'd0;
        isBadAddr    = 1'b0;
        invalid_addr = 32'd0;
        excPC        = 32'd0;
        inDelaySlot  = 1'b0;
        ERET2pc      = 1'b0;
        cp0_write    = 1'b0;
        if (state == IDLE) begin
            exception   = win;
            excPC       = m_pc;
            inDelaySlot = m_in_delay_slot;
            ERET2pc     = eret_commit;
            cp0_write   = accept && !hit && !m_eret && m_cp0_write;
            if (win) begin
                m_excCode = code;
                isBadAddr = is_bad_addr;
                if (is_bad_addr) invalid_addr = bad_sel ? m_pc : m_data_addr;
            end
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            IDLE: begin
                if (win || eret_commit) begin
                    state_next   = FLUSH;
                    counter_next = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (counter == 4'd0) state_next = IDLE;
                else                 counter_next = counter - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // A pending interrupt is only retired by the accept that it actually wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            counter        <= 4'd0;
            int_pending    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state          <= state_next;
            counter        <= counter_next;
            int_pending    <= interrupt | (int_pending & ~(win & int_pending));
            redirect_valid <= win | eret_commit;
            if (win)              redirect_pc <= EXC_VECTOR;
            else if (eret_commit) redirect_pc <= cp0_epc;
        end
    end

    assign flush = (state == FLUSH);

endmodule
